hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage core. Drives the stall (enable) and flush (clear) controls of the F/D, D/E, E/M and M/W pipeline registers, and the operand-forwarding selects for the execute-stage ALU. Resolves load-use hazards, branch/jump redirects and multi-cycle data-memory accesses, and keeps a stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_forward_unit.sv | 32 +++
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t : memory-wait sequencer states (RUN, WAIT, TIMEOUT)
//   FWD_*      : execute-stage operand forward selects
//   RES_LOAD   : result-source encoding that marks a load in E
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT    = 2'b01,
    TIMEOUT = 2'b10
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// forward_unit
// Combinational forward select for one execute-stage source operand.
// Ports:
//   rs          : source register read in E
//   rd_m, rd_w  : destination registers in M and W
//   reg_write_m : M will write rd_m
//   reg_write_w : W will write rd_w
//   sel         : FWD_MEM, FWD_WB or FWD_RF
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  output logic [1:0]                sel
);

  // The younger result in M wins over W; x0 never carries a hazard.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard and sequencing controller for the five-stage core: stall/flush
// controls for the pipeline registers, ALU operand forward selects, a
// data-memory wait sequencer with sticky timeout, and a stall-cycle counter.
//
// Build option HAZARD_FWD_EN:
//   defined   - forwarding from M/W into E; only load-use stalls.
//   undefined - forward selects tied to FWD_RF; any D source matching a
//               writing rdE/rdM stalls like a load-use (W is covered by the
//               register file writing on the falling edge).
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   rs1D_i, rs2D_i                decode-stage sources
//   rs1E_i, rs2E_i, rdE_i         execute-stage sources / destination
//   rdM_i, rdW_i                  memory / writeback destinations
//   reg_write{E,M,W}_i            register-write enables per stage
//   result_srcE_i                 result select in E (RES_LOAD = load)
//   pc_srcE_i                     taken branch/jump resolved in E
//   mem_accessM_i, mem_ready_i    data-memory access in M / completion
//   forward_aE_o, forward_bE_o    ALU operand forward selects
//   stall{F,D,E,M}_o              hold the register feeding that stage
//   flush{D,E,W}_o                bubble into that stage's register
//   mem_timeout_o                 sticky data-memory timeout
//   stall_count_o                 saturating count of stalled cycles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int MAX_WAIT_CYCLES = 16,
  parameter int PERF_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
  input  logic                      reg_writeE_i,
  input  logic                      reg_writeM_i,
  input  logic                      reg_writeW_i,
  input  logic [1:0]                result_srcE_i,
  input  logic                      pc_srcE_i,
  input  logic                      mem_accessM_i,
  input  logic                      mem_ready_i,
  output logic [1:0]                forward_aE_o,
  output logic [1:0]                forward_bE_o,
  output logic                      stallF_o,
  output logic                      stallD_o,
  output logic                      stallE_o,
  output logic                      stallM_o,
  output logic                      flushD_o,
  output logic                      flushE_o,
  output logic                      flushW_o,
  output logic                      mem_timeout_o,
  output logic [PERF_WIDTH-1:0]     stall_count_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT_CYCLES - 1);

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_count;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              load_use;
  logic              data_hazard;
  logic              mem_stall;
  logic              hz_stall;
  logic              redirect;
  logic              any_stall;

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs          (rs1E_i),
    .rd_m        (rdM_i),
    .rd_w        (rdW_i),
    .reg_write_m (reg_writeM_i),
    .reg_write_w (reg_writeW_i),
    .sel         (fwd_a)
  );

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs          (rs2E_i),
    .rd_m        (rdM_i),
    .rd_w        (rdW_i),
    .reg_write_m (reg_writeM_i),
    .reg_write_w (reg_writeW_i),
    .sel         (fwd_b)
  );

  assign load_use = (result_srcE_i == RES_LOAD) && (rdE_i != '0) &&
                    ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

`ifdef HAZARD_FWD_EN
  assign data_hazard  = load_use;
  assign forward_aE_o = rst_i ? FWD_RF : fwd_a;
  assign forward_bE_o = rst_i ? FWD_RF : fwd_b;
`else
  // Without forwarding every in-flight E/M writer must reach the register
  // file before D may read it.
  assign data_hazard = load_use ||
    (reg_writeE_i && (rdE_i != '0) && ((rdE_i == rs1D_i) || (rdE_i == rs2D_i))) ||
    (reg_writeM_i && (rdM_i != '0) && ((rdM_i == rs1D_i) || (rdM_i == rs2D_i)));
  assign forward_aE_o = FWD_RF;
  assign forward_bE_o = FWD_RF;
`endif

  // Controls are forced idle while reset is held so the pipeline sees a
  // clean state even if the memory side is still mid-access.
  assign mem_stall = !rst_i &&
                     (((state == RUN) && mem_accessM_i && !mem_ready_i) ||
                      ((state == WAIT) && !mem_ready_i) ||
                      (state == TIMEOUT));

  // A memory freeze dominates everything; a redirect cancels the load-use
  // stall since the stalled instruction is being squashed anyway.
  assign hz_stall = !rst_i && data_hazard && !pc_srcE_i && !mem_stall;
  assign redirect = !rst_i && pc_srcE_i && !mem_stall;

  assign stallF_o = mem_stall || hz_stall;
  assign stallD_o = mem_stall || hz_stall;
  assign stallE_o = mem_stall;
  assign stallM_o = mem_stall;
  assign flushW_o = mem_stall;
  assign flushD_o = redirect;
  assign flushE_o = redirect || hz_stall;

  assign any_stall = stallF_o || stallD_o || stallE_o || stallM_o;

  // Memory-wait sequencer: wait_count holds the number of stalled cycles of
  // the current access, so the access that would exceed MAX_WAIT_CYCLES
  // lands in TIMEOUT, which only reset leaves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      wait_count    <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_accessM_i && !mem_ready_i) begin
            if (MAX_WAIT_CYCLES <= 1) begin
              state         <= TIMEOUT;
              mem_timeout_o <= 1'b1;
            end else begin
              state      <= WAIT;
              wait_count <= WAIT_W'(1);
            end
          end
        end
        WAIT: begin
          if (mem_ready_i) begin
            state      <= RUN;
            wait_count <= '0;
          end else if (wait_count >= WAIT_LAST) begin
            state         <= TIMEOUT;
            wait_count    <= WAIT_W'(MAX_WAIT_CYCLES);
            mem_timeout_o <= 1'b1;
          end else begin
            wait_count <= wait_count + WAIT_W'(1);
          end
        end
        TIMEOUT: begin
          state <= TIMEOUT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Saturating performance counter of stalled cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_count_o <= '0;
    end else if (any_stall && (stall_count_o != '1)) begin
      stall_count_o <= stall_count_o + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed-vector scoreboard bench for hazard_ctrl. Each vector is driven
// just after a rising edge with its hand-derived expected outputs queued;
// a monitor samples the DUT on the falling edge and compares.
// Works with and without HAZARD_FWD_EN.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       wE, wM, wW;
    logic [1:0] res;
    logic       pc, acc, rdy;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic        sF, sD, sE, sM, fD, fE, fW, tmo;
    logic [31:0] cnt;
  } exp_t;

`ifdef HAZARD_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  // Control patterns, bit order {sF, sD, sE, sM, fD, fE, fW}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] HAZ  = 7'b1100010;
  localparam logic [6:0] RDR  = 7'b0000110;
  localparam logic [6:0] MEMW = 7'b1111001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0;
  logic [4:0]  rdE = '0, rdM = '0, rdW = '0;
  logic        wE = 1'b0, wM = 1'b0, wW = 1'b0;
  logic [1:0]  res = '0;
  logic        pc = 1'b0, acc = 1'b0, rdy = 1'b0;
  logic [1:0]  fa, fb;
  logic        sF, sD, sE, sM, fD, fE, fW, tmo;
  logic [31:0] cnt;

  int    vectors = 0;
  int    miscompares = 0;
  int    expCount = 0;
  exp_t  expQ[$];
  string nameQ[$];

  hazard_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rs1D_i        (rs1D),
    .rs2D_i        (rs2D),
    .rs1E_i        (rs1E),
    .rs2E_i        (rs2E),
    .rdE_i         (rdE),
    .rdM_i         (rdM),
    .rdW_i         (rdW),
    .reg_writeE_i  (wE),
    .reg_writeM_i  (wM),
    .reg_writeW_i  (wW),
    .result_srcE_i (res),
    .pc_srcE_i     (pc),
    .mem_accessM_i (acc),
    .mem_ready_i   (rdy),
    .forward_aE_o  (fa),
    .forward_bE_o  (fb),
    .stallF_o      (sF),
    .stallD_o      (sD),
    .stallE_o      (sE),
    .stallM_o      (sM),
    .flushD_o      (fD),
    .flushE_o      (fE),
    .flushW_o      (fW),
    .mem_timeout_o (tmo),
    .stall_count_o (cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic exp_t ex(input logic [1:0] a, input logic [1:0] b,
                              input logic [6:0] ctl, input logic t);
    exp_t e;
    e.fa = a;
    e.fb = b;
    {e.sF, e.sD, e.sE, e.sM, e.fD, e.fE, e.fW} = ctl;
    e.tmo = t;
    e.cnt = '0;
    return e;
  endfunction

  task automatic applyStimulus(input string name, input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst = s.rst;   rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
    rdE = s.rdE;   rdM = s.rdM;   rdW = s.rdW;
    wE = s.wE;     wM = s.wM;     wW = s.wW;
    res = s.res;   pc = s.pc;     acc = s.acc;   rdy = s.rdy;
    if (s.rst) begin
      expCount = 0;
      e.cnt = 0;
    end else begin
      e.cnt = expCount;
      if (e.sF || e.sD || e.sE || e.sM) expCount++;
    end
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput(input exp_t e, input string name);
    exp_t act;
    act.fa = fa;  act.fb = fb;
    act.sF = sF;  act.sD = sD;  act.sE = sE;  act.sM = sM;
    act.fD = fD;  act.fE = fE;  act.fW = fW;
    act.tmo = tmo;
    act.cnt = cnt;
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("[TB] FAIL %s: got fwd=%b/%b stall=%b%b%b%b flush=%b%b%b tmo=%b cnt=%0d, expected fwd=%b/%b stall=%b%b%b%b flush=%b%b%b tmo=%b cnt=%0d",
               name, act.fa, act.fb, act.sF, act.sD, act.sE, act.sM, act.fD, act.fE, act.fW,
               act.tmo, act.cnt, e.fa, e.fb, e.sF, e.sD, e.sE, e.sM, e.fD, e.fE, e.fW,
               e.tmo, e.cnt);
    end
  endtask

  // Monitor: the DUT presents a full set of outputs every cycle.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(e, n);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;

    s = idle(); s.rst = 1'b1;
    applyStimulus("reset", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));
    s = idle();
    applyStimulus("idle_after_reset", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));

    // Forwarding priority and the W fallback
    s = idle(); s.rdM = 5; s.wM = 1; s.rdW = 5; s.wW = 1; s.rs1E = 5;
    applyStimulus("fwd_m_over_w", s, ex(FWD_ON ? FWD_MEM : FWD_RF, FWD_RF, NONE, 1'b0));
    s.rdM = 0;
    applyStimulus("fwd_w_when_m_x0", s, ex(FWD_ON ? FWD_WB : FWD_RF, FWD_RF, NONE, 1'b0));
    s = idle(); s.rdW = 6; s.wW = 1; s.rs2E = 6;
    applyStimulus("fwd_b_from_w", s, ex(FWD_RF, FWD_ON ? FWD_WB : FWD_RF, NONE, 1'b0));
    s = idle(); s.rdM = 0; s.wM = 1; s.rs1E = 0;
    applyStimulus("fwd_x0_ignored", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));

    // Load-use: one stall cycle, then clear
    s = idle(); s.res = RES_LOAD; s.rdE = 7; s.wE = 1; s.rs2D = 7;
    applyStimulus("load_use", s, ex(FWD_RF, FWD_RF, HAZ, 1'b0));
    s = idle();
    applyStimulus("load_use_release", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));
    s = idle(); s.res = RES_LOAD; s.rdE = 0; s.wE = 1;
    applyStimulus("load_x0", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));

    // Redirect beats load-use
    s = idle(); s.res = RES_LOAD; s.rdE = 7; s.wE = 1; s.rs1D = 7; s.pc = 1;
    applyStimulus("redirect_over_load_use", s, ex(FWD_RF, FWD_RF, RDR, 1'b0));

    // Dependencies that only stall without forwarding
    s = idle(); s.rdM = 3; s.wM = 1; s.rs1D = 3;
    applyStimulus("dep_m_rs1D", s, ex(FWD_RF, FWD_RF, FWD_ON ? NONE : HAZ, 1'b0));
    s = idle(); s.rdE = 4; s.wE = 1; s.rs2D = 4;
    applyStimulus("dep_e_rs2D", s, ex(FWD_RF, FWD_RF, FWD_ON ? NONE : HAZ, 1'b0));
    s = idle(); s.rdW = 9; s.wW = 1; s.rs1D = 9;
    applyStimulus("dep_w_no_stall", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));
    s = idle(); s.rdM = 3; s.wM = 0; s.rs1D = 3;
    applyStimulus("dep_m_no_write", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));

    // Three-cycle memory wait, with a load-use and a redirect arriving
    // mid-wait; the redirect is re-presented when the wait ends.
    s = idle(); s.acc = 1;
    applyStimulus("mem_wait_1", s, ex(FWD_RF, FWD_RF, MEMW, 1'b0));
    s.res = RES_LOAD; s.rdE = 7; s.wE = 1; s.rs2D = 7; s.pc = 1;
    applyStimulus("mem_wait_2_masks", s, ex(FWD_RF, FWD_RF, MEMW, 1'b0));
    s = idle(); s.acc = 1;
    applyStimulus("mem_wait_3", s, ex(FWD_RF, FWD_RF, MEMW, 1'b0));
    s.rdy = 1; s.pc = 1;
    applyStimulus("mem_ready_release", s, ex(FWD_RF, FWD_RF, RDR, 1'b0));
    s = idle(); s.acc = 1; s.rdy = 1;
    applyStimulus("mem_ready_first", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));
    s = idle();
    applyStimulus("idle_after_mem", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));

    // Timeout after 16 unready cycles, held until reset
    s = idle(); s.acc = 1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus($sformatf("timeout_wait_%0d", i + 1), s, ex(FWD_RF, FWD_RF, MEMW, 1'b0));
    end
    applyStimulus("timeout_flag", s, ex(FWD_RF, FWD_RF, MEMW, 1'b1));
    s.rdy = 1;
    applyStimulus("timeout_sticky", s, ex(FWD_RF, FWD_RF, MEMW, 1'b1));
    s = idle(); s.acc = 1; s.rst = 1;
    applyStimulus("reset_in_timeout", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));
    s = idle();
    applyStimulus("run_after_reset", s, ex(FWD_RF, FWD_RF, NONE, 1'b0));

    repeat (2) @(posedge clk);
    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
